icache_axi_responder: RTL and testbench
=======================================

# icache_axi_responder

AXI4 read-only responder: the slave end of the instruction-cache refill channel. Accepts one AR request at a time and returns the requested burst on R from an internal word-addressed memory, with a programmable first-beat latency and full R-channel backpressure. It serves as the memory side for ICache refill in simulation and FPGA bring-up. A side write port preloads the memory.

## Interface

- ID_WIDTH, 4, AXI ID width
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 64, R data width (power of two, ≥32)
- DEPTH, 4096, memory depth in DATA_WIDTH words
- LATENCY, 2, idle cycles between AR handshake and first R beat (0–15)

Ports:

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- arvalid  in  1  AR valid
- arready  out  1  AR ready
- arid  in  ID_WIDTH  request ID
- araddr  in  ADDR_WIDTH  start byte address
- arlen  in  8  beats minus one
- arsize  in  3  log2 bytes per beat
- arburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- rvalid  out  1  R valid
- rready  in  1  R ready
- rid  out  ID_WIDTH  echoes arid
- rdata  out  DATA_WIDTH  beat data
- rresp  out  2  0 OKAY, 2 SLVERR
- rlast  out  1  final beat
- init_we  in  1  preload write enable
- init_idx  in  $clog2(DEPTH)  preload word index
- init_wdata  in  DATA_WIDTH  preload data

## Operation

- Let B = DATA_WIDTH/8 and W = $clog2(B). Word index = addr[ADDR_WIDTH-1:W].
- FSM states: IDLE, WAIT, BURST.
  - IDLE: arready=1. On arvalid, latch id, addr, len, size, burst, and beat count 0. Go to WAIT if LATENCY>0, otherwise go to BURST.
  - WAIT: the latency counter counts LATENCY cycles, then the FSM goes to BURST.
  - BURST: presents beats. After the beat with rlast=1 handshakes, the FSM returns to IDLE.
- Request error: the request is an error if arsize>W or arburst==3. For WRAP, it is also an error if len+1 is not in {2,4,8,16} or the address is not aligned to 1<<size. An error request returns all len+1 beats with rresp=SLVERR and rdata=0, with rlast on the final beat. The protocol is never truncated.
- Per-beat error: a beat whose word index is ≥DEPTH returns SLVERR with rdata=0. Other beats return OKAY with rdata=mem[index]. The full word is always returned, regardless of size.
- Address update after each beat handshake:
  - FIXED: the address is unchanged.
  - INCR: addr += 1<<size, computed in ADDR_WIDTH bits with modular wrap.
  - WRAP: the span is (len+1)<<size. addr = (addr & ~(span-1)) | ((addr+(1<<size)) & (span-1)).
- rlast=1 when the beat counter equals the latched len.
- rid equals the latched arid on every beat.
- Preload: when init_we=1, mem[init_idx] is written at the clock edge, at any time including mid-burst. If a preload and an R-beat fetch hit the same index in the same cycle, the beat carries the old data (read-before-write).

## Timing

- Reset (rst=0, async): FSM→IDLE and all counters cleared. Reset values: arready=0 during reset and 1 in the first cycle after release; rvalid=0, rlast=0, rresp=0, rid=0, rdata=0. Memory contents are not cleared. Reset asserted mid-burst abandons the burst immediately.
- The AR handshake happens in cycle T. arready=0 from T+1 until the cycle after the final R handshake. Only one request is outstanding at a time.
- First rvalid is at T+1+LATENCY.
- Beats are registered. While rvalid=1 and rready=0, rdata, rresp, rlast and rid hold stable.
- With rready held high, the block issues one beat per cycle, so a len=N burst takes N+1 consecutive cycles.
- The earliest next AR handshake is the cycle after the last-beat handshake, which gives a 1-cycle bubble.
- rvalid never drops before its handshake completes.

## Test plan

- Preload mem[i]=i*0x1111 for i in 0..15. Then send AR with addr=0x20, len=3, size=3, INCR, id=5, LATENCY=2, rready=1. Required: rvalid first at T+3; data 0x4444, 0x5555, 0x6666, 0x7777; rid=5; rresp=0; rlast only on beat 4; arready=1 at T+7.
- WRAP with addr=0x28, len=3, size=3. Required: indices 5, 6, 7, 4, in that order.
- Same INCR request with rready toggled 1,0,0,1,… Required: each beat holds stable while rready=0; no beat is lost or duplicated.
- Request with arsize=4 (DATA_WIDTH=64), len=1. Required: two beats, both rresp=2, rdata=0, rlast on the second. Separately, INCR starting at the last valid word (index DEPTH-1), len=1. Required: beat 0 is OKAY and beat 1 is SLVERR.
- Assert rst during beat 2 of a len=7 burst. Required: rvalid=0 immediately; arready=1 in the first cycle after release; a new request completes normally.
- LATENCY=0 with FIXED burst, len=2, addr=0x10. Required: rvalid at T+1 and three beats, all with data mem[2].

Source files
------------

// File: rtl/icache_axi_responder.sv
// AXI4 read-only responder backing ICache refill: one AR at a time, registered
// R beats from a preloadable word memory with programmable first-beat latency.
//   state   | meaning
//   S_IDLE  | arready high, waiting for a request
//   S_WAIT  | counting down first-beat latency
//   S_BURST | presenting beats until rlast handshakes
module icache_axi_responder #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4096,
  parameter int LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [ID_WIDTH-1:0]      arid,
  input  logic [ADDR_WIDTH-1:0]    araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [ID_WIDTH-1:0]      rid,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  input  logic                     init_we,
  input  logic [$clog2(DEPTH)-1:0] init_idx,
  input  logic [DATA_WIDTH-1:0]    init_wdata
);

  localparam int W      = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int WORD_W = ADDR_WIDTH - W;
  localparam logic [ADDR_WIDTH-1:0] ONE     = 1;
  localparam logic [WORD_W-1:0]     DEPTH_W = WORD_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t                  state;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    err_q;
  logic [3:0]              wait_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   f_addr;
  logic [7:0]              f_beat;
  logic [7:0]              f_len;
  logic                    f_err;
  logic [WORD_W-1:0]       f_word;
  logic [DATA_WIDTH-1:0]   f_data;
  logic [1:0]              f_resp;
  logic                    f_last;

  function automatic logic req_error(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len, input logic [ADDR_WIDTH-1:0] addr);
    logic bad;
    bad = (32'(size) > W) || (burst == 2'd3);
    if (burst == 2'd2) begin
      if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) bad = 1'b1;
      if ((addr & ((ONE << size) - ONE)) != '0) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0] size, input logic [1:0] burst,
                                                      input logic [7:0] len);
    logic [ADDR_WIDTH-1:0] step, mask;
    step = ONE << size;
    mask = ((ADDR_WIDTH'(len) + ONE) << size) - ONE;
    case (burst)
      2'd0:    return addr;
      2'd2:    return (addr & ~mask) | ((addr + step) & mask);
      default: return addr + step;
    endcase
  endfunction

  // The beat that would be loaded at the coming edge: from AR in IDLE,
  // the latched start in WAIT, the successor of the current beat in BURST.
  always_comb begin
    f_addr = addr_q;
    f_beat = beat_q;
    f_len  = len_q;
    f_err  = err_q;
    if (state == S_IDLE) begin
      f_addr = araddr;
      f_beat = 8'd0;
      f_len  = arlen;
      f_err  = req_error(arsize, arburst, arlen, araddr);
    end else if (state == S_BURST) begin
      f_addr = next_addr(addr_q, size_q, burst_q, len_q);
      f_beat = beat_q + 8'd1;
    end
    f_word = f_addr[ADDR_WIDTH-1:W];
    f_last = (f_beat == f_len);
    f_data = '0;
    f_resp = 2'd2;
    if (!f_err && (f_word < DEPTH_W)) begin
      f_data = mem[f_word[IDX_W-1:0]];
      f_resp = 2'd0;
    end
  end

  assign arready = rst && (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (init_we) mem[init_idx] <= init_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
      rvalid  <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= '0;
      rlast   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arvalid) begin
            id_q    <= arid;
            addr_q  <= araddr;
            len_q   <= arlen;
            size_q  <= arsize;
            burst_q <= arburst;
            err_q   <= f_err;
            beat_q  <= 8'd0;
            if (LATENCY == 0) begin
              state  <= S_BURST;
              rvalid <= 1'b1;
              rid    <= arid;
              rdata  <= f_data;
              rresp  <= f_resp;
              rlast  <= f_last;
            end else begin
              wait_q <= 4'(LATENCY - 1);
              state  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_q == 4'd0) begin
            state  <= S_BURST;
            rvalid <= 1'b1;
            rid    <= id_q;
            rdata  <= f_data;
            rresp  <= f_resp;
            rlast  <= f_last;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        S_BURST: begin
          if (rready) begin
            if (rlast) begin
              state  <= S_IDLE;
              rvalid <= 1'b0;
              rlast  <= 1'b0;
            end else begin
              addr_q <= f_addr;
              beat_q <= f_beat;
              rid    <= id_q;
              rdata  <= f_data;
              rresp  <= f_resp;
              rlast  <= f_last;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_axi_responder.sv
// Directed bench for icache_axi_responder: one instance with LATENCY=2, one with
// LATENCY=0, sharing the preload port so both memories hold the same image.
module tb_icache_axi_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arvalid_a = 1'b0, arvalid_b = 1'b0;
  logic        arready_a, arready_b;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        rvalid_a, rvalid_b;
  logic        rready = 1'b1;
  logic [3:0]  rid_a, rid_b;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rresp_a, rresp_b;
  logic        rlast_a, rlast_b;
  logic        init_we = 1'b0;
  logic [11:0] init_idx = '0;
  logic [63:0] init_wdata = '0;

  bit use0 = 1'b0;
  int checks = 0;
  int errors = 0;

  logic [63:0] got_data[$];
  logic [1:0]  got_resp[$];
  logic        got_last[$];
  logic [3:0]  got_id[$];
  logic [63:0] exp_data[$];
  logic [1:0]  exp_resp[$];

  wire        m_arready = use0 ? arready_b : arready_a;
  wire        m_rvalid  = use0 ? rvalid_b  : rvalid_a;
  wire [3:0]  m_rid     = use0 ? rid_b     : rid_a;
  wire [63:0] m_rdata   = use0 ? rdata_b   : rdata_a;
  wire [1:0]  m_rresp   = use0 ? rresp_b   : rresp_a;
  wire        m_rlast   = use0 ? rlast_b   : rlast_a;

  always #5 clk = ~clk;

  icache_axi_responder #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid_a), .arready(arready_a), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid_a), .rready(rready), .rid(rid_a), .rdata(rdata_a),
    .rresp(rresp_a), .rlast(rlast_a),
    .init_we(init_we), .init_idx(init_idx), .init_wdata(init_wdata)
  );

  icache_axi_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .arvalid(arvalid_b), .arready(arready_b), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid_b), .rready(rready), .rid(rid_b), .rdata(rdata_b),
    .rresp(rresp_b), .rlast(rlast_b),
    .init_we(init_we), .init_idx(init_idx), .init_wdata(init_wdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of cycle T+1 after the AR handshake.
  task automatic send(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                      input logic [1:0] b, input logic [3:0] id);
    bit got;
    got = 1'b0;
    araddr = a; arlen = l; arsize = s; arburst = b; arid = id;
    if (use0) arvalid_b = 1'b1; else arvalid_a = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (m_arready) got = 1'b1;
      step();
    end
    arvalid_a = 1'b0;
    arvalid_b = 1'b0;
    chk("ar_handshake", 64'(got), 64'd1);
  endtask

  // pat 0: rready always 1; pat 1: rready 1,0,0,1 repeating.
  task automatic collect(input int pat, output int cycles);
    logic [63:0] sd; logic [1:0] sr; logic sl; logic [3:0] si;
    bit stall, done;
    stall = 1'b0; done = 1'b0; cycles = 0;
    sd = '0; sr = '0; sl = 1'b0; si = '0;
    got_data.delete(); got_resp.delete(); got_last.delete(); got_id.delete();
    for (int k = 0; k < 200 && !done; k++) begin
      rready = (pat == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      if (stall) begin
        chk("hold_valid", 64'(m_rvalid), 64'd1);
        chk("hold_data", m_rdata, sd);
        chk("hold_resp", 64'(m_rresp), 64'(sr));
        chk("hold_last", 64'(m_rlast), 64'(sl));
        chk("hold_id", 64'(m_rid), 64'(si));
      end
      if (m_rvalid && rready) begin
        got_data.push_back(m_rdata);
        got_resp.push_back(m_rresp);
        got_last.push_back(m_rlast);
        got_id.push_back(m_rid);
        if (m_rlast) done = 1'b1;
      end
      stall = m_rvalid && !rready;
      sd = m_rdata; sr = m_rresp; sl = m_rlast; si = m_rid;
      cycles++;
      if (!done) step();
    end
    rready = 1'b1;
    chk("collect_done", 64'(done), 64'd1);
  endtask

  task automatic verify(input string tag, input logic [3:0] id);
    int n;
    n = exp_data.size();
    chk({tag, "_count"}, 64'(got_data.size()), 64'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
      chk($sformatf("%s_resp%0d", tag, i), 64'(got_resp[i]), 64'(exp_resp[i]));
      chk($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == n - 1));
      chk($sformatf("%s_id%0d", tag, i), 64'(got_id[i]), 64'(id));
    end
  endtask

  task automatic set_exp4(input logic [63:0] d0, d1, d2, d3);
    exp_data = '{d0, d1, d2, d3};
    exp_resp = '{2'd0, 2'd0, 2'd0, 2'd0};
  endtask

  initial begin
    int cyc;

    // Reset state
    step();
    step();
    chk("rst_arready", 64'(arready_a), 64'd0);
    chk("rst_rvalid", 64'(rvalid_a), 64'd0);
    chk("rst_rlast", 64'(rlast_a), 64'd0);
    chk("rst_rresp", 64'(rresp_a), 64'd0);
    chk("rst_rid", 64'(rid_a), 64'd0);
    chk("rst_rdata", rdata_a, 64'd0);
    rst = 1'b1;
    #1;
    chk("rel_arready", 64'(arready_a), 64'd1);
    @(negedge clk);

    // Preload mem[i] = i*0x1111 and a marker in the last word
    for (int i = 0; i < 16; i++) begin
      init_we = 1'b1; init_idx = 12'(i); init_wdata = 64'(i) * 64'h1111;
      step();
    end
    init_we = 1'b1; init_idx = 12'd4095; init_wdata = 64'hCAFE_F00D_1234_5678;
    step();
    init_we = 1'b0;

    // INCR, latency 2, timing checks
    send(32'h20, 8'd3, 3'd3, 2'd1, 4'd5);
    chk("t1_rvalid_T1", 64'(rvalid_a), 64'd0);
    chk("t1_arready_T1", 64'(arready_a), 64'd0);
    step();
    chk("t1_rvalid_T2", 64'(rvalid_a), 64'd0);
    step();
    chk("t1_rvalid_T3", 64'(rvalid_a), 64'd1);
    collect(0, cyc);
    chk("t1_cycles", 64'(cyc), 64'd4);
    set_exp4(64'h4444, 64'h5555, 64'h6666, 64'h7777);
    verify("incr", 4'd5);
    chk("t1_arready_busy", 64'(arready_a), 64'd0);
    step();
    chk("t1_arready_T7", 64'(arready_a), 64'd1);
    chk("t1_rvalid_T7", 64'(rvalid_a), 64'd0);

    // WRAP: indices 5,6,7,4
    send(32'h28, 8'd3, 3'd3, 2'd2, 4'd9);
    collect(0, cyc);
    set_exp4(64'h5555, 64'h6666, 64'h7777, 64'h4444);
    verify("wrap", 4'd9);
    step();

    // INCR under rready backpressure
    send(32'h20, 8'd3, 3'd3, 2'd1, 4'd3);
    collect(1, cyc);
    set_exp4(64'h4444, 64'h5555, 64'h6666, 64'h7777);
    verify("bp", 4'd3);
    step();

    // Oversized arsize: whole request errors
    send(32'h0, 8'd1, 3'd4, 2'd1, 4'd2);
    collect(0, cyc);
    exp_data = '{64'd0, 64'd0};
    exp_resp = '{2'd2, 2'd2};
    verify("size_err", 4'd2);
    step();

    // INCR from the last valid word runs off the end
    send(32'h7FF8, 8'd1, 3'd3, 2'd1, 4'd7);
    collect(0, cyc);
    exp_data = '{64'hCAFE_F00D_1234_5678, 64'd0};
    exp_resp = '{2'd0, 2'd2};
    verify("edge", 4'd7);
    step();

    // Reset mid-burst
    send(32'h0, 8'd7, 3'd3, 2'd1, 4'd1);
    step();
    step();
    step();
    step();
    chk("mid_rvalid_before", 64'(rvalid_a), 64'd1);
    chk("mid_beat2", rdata_a, 64'h2222);
    rst = 1'b0;
    #1;
    chk("mid_rvalid_rst", 64'(rvalid_a), 64'd0);
    chk("mid_arready_rst", 64'(arready_a), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_arready_rel", 64'(arready_a), 64'd1);
    @(negedge clk);
    send(32'h20, 8'd3, 3'd3, 2'd1, 4'd6);
    collect(0, cyc);
    set_exp4(64'h4444, 64'h5555, 64'h6666, 64'h7777);
    verify("after_rst", 4'd6);
    step();

    // LATENCY=0, FIXED burst
    use0 = 1'b1;
    send(32'h10, 8'd2, 3'd3, 2'd0, 4'd4);
    chk("lat0_rvalid_T1", 64'(rvalid_b), 64'd1);
    collect(0, cyc);
    chk("lat0_cycles", 64'(cyc), 64'd3);
    exp_data = '{64'h2222, 64'h2222, 64'h2222};
    exp_resp = '{2'd0, 2'd0, 2'd0};
    verify("fixed", 4'd4);
    step();
    chk("lat0_arready_after", 64'(arready_b), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
